// File: rtl/memwb_pipe_buf.sv
// ============================================================================
// Module   : memwb_pipe_buf
// Brief    : MEM->WB pipeline stage carrying {wb, data, addr, rw} through a
//            2-entry skid buffer, with valid/ready handshake, flush and $zero
//            write suppression. Optional MEMWB_FWD_EN adds a forwarding lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memwb_pipe_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int RW_W   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [RW_W-1:0]   in_rw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [RW_W-1:0]   out_rw
`ifdef MEMWB_FWD_EN
  ,
  input  logic [RW_W-1:0]   fwd_rs,
  input  logic [RW_W-1:0]   fwd_rt,
  output logic              fwd_rs_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rt_data
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_h_wb;
  logic [DATA_W-1:0]   r_h_data;
  logic [ADDR_W-1:0]   r_h_addr;
  logic [RW_W-1:0]     r_h_rw;

  logic                r_s_wb;
  logic [DATA_W-1:0]   r_s_data;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [RW_W-1:0]     r_s_rw;

  logic                w_acc;
  logic                w_rel;
  logic                w_ld_h_in;
  logic                w_ld_s_in;
  logic                w_mv_s_h;
  logic                w_wb_in;

  // Handshake flags depend only on the state register, never on out_ready.
  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_wb    = r_h_wb & out_valid;
  assign out_data  = r_h_data;
  assign out_addr  = r_h_addr;
  assign out_rw    = r_h_rw;

  assign w_acc   = in_valid & in_ready;
  assign w_rel   = out_valid & out_ready;
  assign w_wb_in = in_wb & (in_rw != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_ld_h_in   = 1'b0;
    w_ld_s_in   = 1'b0;
    w_mv_s_h    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = ST_ONE;
          w_ld_h_in   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && !w_rel) begin
          w_state_nxt = ST_FULL;
          w_ld_s_in   = 1'b1;
        end else if (w_acc && w_rel) begin
          w_ld_h_in   = 1'b1;
        end else if (w_rel) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_rel) begin
          w_state_nxt = ST_ONE;
          w_mv_s_h    = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any transfer; held head fields stay as last shown.
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_ld_h_in   = 1'b0;
      w_ld_s_in   = 1'b0;
      w_mv_s_h    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_EMPTY;
      r_h_wb   <= 1'b0;
      r_h_data <= '0;
      r_h_addr <= '0;
      r_h_rw   <= '0;
      r_s_wb   <= 1'b0;
      r_s_data <= '0;
      r_s_addr <= '0;
      r_s_rw   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_h_in) begin
        r_h_wb   <= w_wb_in;
        r_h_data <= in_data;
        r_h_addr <= in_addr;
        r_h_rw   <= in_rw;
      end else if (w_mv_s_h) begin
        r_h_wb   <= r_s_wb;
        r_h_data <= r_s_data;
        r_h_addr <= r_s_addr;
        r_h_rw   <= r_s_rw;
      end
      if (w_ld_s_in) begin
        r_s_wb   <= w_wb_in;
        r_s_data <= in_data;
        r_s_addr <= in_addr;
        r_s_rw   <= in_rw;
      end
    end
  end

`ifdef MEMWB_FWD_EN
  logic w_h_live;
  logic w_s_live;
  logic w_rs_h;
  logic w_rs_s;
  logic w_rt_h;
  logic w_rt_s;

  // Stored wb is already zero for rw==0, the explicit source check is kept for clarity.
  assign w_h_live = (r_state != ST_EMPTY) & r_h_wb;
  assign w_s_live = (r_state == ST_FULL) & r_s_wb;
  assign w_rs_h   = w_h_live & (r_h_rw == fwd_rs) & (fwd_rs != '0);
  assign w_rs_s   = w_s_live & (r_s_rw == fwd_rs) & (fwd_rs != '0);
  assign w_rt_h   = w_h_live & (r_h_rw == fwd_rt) & (fwd_rt != '0);
  assign w_rt_s   = w_s_live & (r_s_rw == fwd_rt) & (fwd_rt != '0);

  assign fwd_rs_hit  = w_rs_h | w_rs_s;
  assign fwd_rt_hit  = w_rt_h | w_rt_s;
  assign fwd_rs_data = w_rs_s ? r_s_data : (w_rs_h ? r_h_data : '0);
  assign fwd_rt_data = w_rt_s ? r_s_data : (w_rt_h ? r_h_data : '0);
`endif

endmodule

`default_nettype wire
